// File: rtl/nes_pad_responder.sv
// rtl/nes_pad_responder.sv - NES/SNES serial pad endpoint driven by an external latch/clock poller
// Define NES_PAD_SNES_EN for the 16-bit SNES frame; the default build sends the 8-bit NES frame.
module nes_pad_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] buttons,
  input  logic        nes_latch,
  input  logic        nes_clk,
  output logic        nes_data,
  output logic        frame_done,
  output logic [7:0]  poll_count
);

`ifdef NES_PAD_SNES_EN
  localparam int NBITS = 16;
  localparam int NBTN  = 12;
`else
  localparam int NBITS = 8;
  localparam int NBTN  = 8;
  logic unused_buttons;
  assign unused_buttons = ^buttons[11:8];
`endif
  localparam logic [3:0] LAST_IDX = 4'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pclk_sync;
  logic [NBTN-1:0]        btn_sync [SYNC_STAGES];
  logic                   latch_d;
  logic                   pclk_d;

  logic            latch_s;
  logic            latch_fall;
  logic            pclk_rise;
  logic [NBTN-1:0] btn_s;

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign latch_fall = ~latch_s & latch_d;
  assign pclk_rise  = pclk_sync[SYNC_STAGES-1] & ~pclk_d;
  assign btn_s      = btn_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_sync <= '0;
      pclk_sync  <= '0;
      latch_d    <= 1'b0;
      pclk_d     <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) btn_sync[i] <= '0;
    end else begin
      latch_sync  <= {latch_sync[SYNC_STAGES-2:0], nes_latch};
      pclk_sync   <= {pclk_sync[SYNC_STAGES-2:0], nes_clk};
      latch_d     <= latch_s;
      pclk_d      <= pclk_sync[SYNC_STAGES-1];
      btn_sync[0] <= buttons[NBTN-1:0];
      for (int i = 1; i < SYNC_STAGES; i++) btn_sync[i] <= btn_sync[i-1];
    end
  end

  // Active-low image; unimplemented positions read as released.
  logic [15:0] load_val;
  always_comb begin
    load_val = '1;
    for (int b = 0; b < NBTN; b++) load_val[b] = ~btn_s[b];
  end

  state_t      state, state_n;
  logic [15:0] sr, sr_n;
  logic [3:0]  bit_idx, idx_n;
  logic        data_n;
  logic        fd_n;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = bit_idx;
    fd_n    = 1'b0;
    data_n  = 1'b1;
    case (state)
      IDLE: begin
        if (latch_s) begin
          state_n = LOAD;
          sr_n    = load_val;
          idx_n   = '0;
        end
      end
      LOAD: begin
        if (latch_fall) begin
          state_n = SHIFT;
          idx_n   = '0;
        end else begin
          sr_n = load_val;
        end
      end
      SHIFT: begin
        // A latch level outranks any clock edge seen in the same cycle.
        if (latch_s) begin
          state_n = LOAD;
          sr_n    = load_val;
          idx_n   = '0;
        end else if (pclk_rise) begin
          sr_n = {1'b0, sr[15:1]};
          if (bit_idx == LAST_IDX) begin
            state_n = DONE;
            fd_n    = 1'b1;
          end else begin
            idx_n = bit_idx + 4'd1;
          end
        end
      end
      DONE: begin
        if (latch_s) begin
          state_n = LOAD;
          sr_n    = load_val;
          idx_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      LOAD, SHIFT: data_n = sr_n[0];
      DONE:        data_n = 1'b0;
      default:     data_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '1;
      bit_idx    <= '0;
      nes_data   <= 1'b1;
      frame_done <= 1'b0;
      poll_count <= '0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bit_idx    <= idx_n;
      nes_data   <= data_n;
      frame_done <= fd_n;
      poll_count <= poll_count + {7'd0, fd_n};
    end
  end

endmodule

// File: tb/tb_nes_pad_responder.sv
// tb/tb_nes_pad_responder.sv - directed and randomized polling of nes_pad_responder against a frame model
module tb_nes_pad_responder;
`ifdef NES_PAD_SNES_EN
  localparam int N  = 16;
  localparam int NB = 12;
  localparam logic [11:0] DIRECTED = 12'hA00;
`else
  localparam int N  = 8;
  localparam int NB = 8;
  localparam logic [11:0] DIRECTED = 12'h011;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] buttons = '0;
  logic        nes_latch = 1'b0;
  logic        nes_clk = 1'b0;
  logic        nes_data;
  logic        frame_done;
  logic [7:0]  poll_count;

  int checks = 0;
  int fails = 0;
  int fd_hi = 0;
  int exp_polls = 0;

  nes_pad_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .buttons(buttons), .nes_latch(nes_latch),
    .nes_clk(nes_clk), .nes_data(nes_data), .frame_done(frame_done),
    .poll_count(poll_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fd_hi <= fd_hi + (frame_done ? 1 : 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit i of a frame as a real pad would send it: pressed = 0, absent button = 1.
  function automatic logic exp_bit(input logic [11:0] b, input int i);
    if (i < NB) return ~b[i];
    return 1'b1;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_frame(input logic [11:0] b);
    int fd0;
    fd0 = fd_hi;
    check("bit0", nes_data, exp_bit(b, 0));
    for (int i = 0; i < N; i++) begin
      nes_clk = 1'b1;
      wait_cyc(5);
      check($sformatf("bit%0d", i + 1), nes_data, (i + 1 < N) ? exp_bit(b, i + 1) : 1'b0);
      nes_clk = 1'b0;
      wait_cyc(5);
    end
    exp_polls = (exp_polls + 1) % 256;
    check("frame_done_pulses", fd_hi - fd0, 1);
    check("poll_count", poll_count, exp_polls);
  endtask

  task automatic run_frame(input logic [11:0] b);
    buttons = b;
    wait_cyc(4);
    nes_latch = 1'b1;
    wait_cyc(6);
    nes_latch = 1'b0;
    wait_cyc(6);
    shift_frame(b);
  endtask

  initial begin
    logic [11:0] b1, b2;
    int fd0;

    wait_cyc(3);
    check("reset_data", nes_data, 1'b1);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_poll_count", poll_count, 8'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    for (int i = 0; i < 5; i++) begin
      nes_clk = 1'b1;
      wait_cyc(5);
      check("idle_stray_clk", nes_data, 1'b1);
      nes_clk = 1'b0;
      wait_cyc(5);
    end
    check("idle_poll_count", poll_count, 8'd0);

    run_frame(DIRECTED);
    for (int k = 0; k < 6; k++) run_frame(12'($urandom));

    nes_clk = 1'b1;
    wait_cyc(5);
    check("done_extra_clk", nes_data, 1'b0);
    nes_clk = 1'b0;
    wait_cyc(5);
    check("done_extra_poll", poll_count, 8'(exp_polls));

    b1 = 12'($urandom);
    b2 = ~b1;
    buttons = b1;
    wait_cyc(4);
    nes_latch = 1'b1;
    wait_cyc(6);
    nes_latch = 1'b0;
    wait_cyc(6);
    fd0 = fd_hi;
    for (int i = 0; i < 3; i++) begin
      nes_clk = 1'b1;
      wait_cyc(5);
      check("abort_pre_bit", nes_data, exp_bit(b1, i + 1));
      nes_clk = 1'b0;
      wait_cyc(5);
    end
    buttons = b2;
    wait_cyc(4);
    nes_latch = 1'b1;
    wait_cyc(6);
    check("abort_load_bit0", nes_data, exp_bit(b2, 0));
    check("abort_no_frame_done", fd_hi - fd0, 0);
    check("abort_poll_count", poll_count, 8'(exp_polls));
    nes_latch = 1'b0;
    wait_cyc(6);
    shift_frame(b2);

    b1 = 12'($urandom);
    buttons = b1;
    wait_cyc(4);
    nes_latch = 1'b1;
    nes_clk = 1'b1;
    wait_cyc(6);
    nes_clk = 1'b0;
    wait_cyc(6);
    nes_latch = 1'b0;
    wait_cyc(6);
    shift_frame(b1);

    b1 = 12'($urandom);
    buttons = b1;
    wait_cyc(4);
    nes_latch = 1'b1;
    wait_cyc(6);
    nes_latch = 1'b0;
    wait_cyc(6);
    for (int i = 0; i < 4; i++) begin
      nes_clk = 1'b1;
      wait_cyc(5);
      nes_clk = 1'b0;
      wait_cyc(5);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midshift_reset_data", nes_data, 1'b1);
    check("midshift_reset_poll", poll_count, 8'd0);
    check("midshift_reset_fd", frame_done, 1'b0);
    exp_polls = 0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(2);
    for (int i = 0; i < 2; i++) begin
      nes_clk = 1'b1;
      wait_cyc(5);
      check("post_reset_idle", nes_data, 1'b1);
      nes_clk = 1'b0;
      wait_cyc(5);
    end
    run_frame(12'($urandom));

    for (int k = 0; k < 255; k++) begin
      run_frame(12'($urandom));
      if (k == 253) check("poll_count_255", poll_count, 8'd255);
    end
    check("poll_count_wrapped", poll_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/nes_pad_responder.md
# nes_pad_responder

Controller-side endpoint of the NES/SNES serial pad protocol: presents up to twelve active-high button inputs to an external console-side poller over the latch/clock/data three-wire link. Sits at the top level between the dedicated input pins (buttons) and the bidirectional pins carrying `NES_Latch`/`NES_Clk` (in) and `NES_Data` (out). It lets a second board, or the bench, act as a gamepad for the receiver path.

## Interface
- `SYNC_STAGES`, 2, number of flip-flop stages synchronising `nes_latch`, `nes_clk` and `buttons` (legal values 2–4).
- `clk`, in, 1, system clock (25.175 MHz pixel clock domain).
- `rst_n`, in, 1, asynchronous active-low reset.
- `buttons`, in, 12, active-high pressed flags.
  - SNES order: [0] B, [1] Y, [2] Select, [3] Start, [4] Up, [5] Down, [6] Left, [7] Right, [8] A, [9] X, [10] L, [11] R.
  - NES mode uses only [7:0], reinterpreted as A, B, Select, Start, Up, Down, Left, Right.
- `nes_latch`, in, 1, asynchronous; high = capture buttons.
- `nes_clk`, in, 1, asynchronous; each rising edge advances one bit.
- `nes_data`, out, 1, serial data, active-low (0 = pressed).
- `frame_done`, out, 1, one-cycle pulse when the final bit has been consumed.
- `poll_count`, out, 8, number of completed polls; wraps from 255 to 0.

## Operation
- **Frame length.** N = 16 with `NES_PAD_SNES_EN` defined, N = 8 otherwise.
- **Input path.** `nes_latch` and `nes_clk` pass through `SYNC_STAGES` flops, then a 1-flop edge detector. `buttons` passes through `SYNC_STAGES` flops.
- **Shift register.** `sr[15:0]`, active-low image.
  - Load value: `sr[b] = ~buttons_s[b]` for each implemented button b; every other bit = 1 (released).
  - The first bit sent is `sr[0]`.
- **States**
  - IDLE: `nes_data` = 1.
  - LOAD: entered while synchronised latch = 1. `sr` reloads every cycle. `nes_data` = live `sr[0]`.
  - SHIFT: entered on the synchronised latch falling edge with `bit_idx` = 0. On each synchronised `nes_clk` rising edge: shift `sr` right, fill with 0, and increment `bit_idx`. When `bit_idx` reaches N−1 and a clock edge arrives, go to DONE and pulse `frame_done`.
  - DONE: `nes_data` = 0. This matches a genuine pad's trailing low bits.
- **Transitions**
  - IDLE → LOAD on latch = 1.
  - LOAD → SHIFT on latch fall.
  - SHIFT or DONE → LOAD on latch = 1. A latch arriving mid-shift aborts the current frame: no `frame_done` pulse and no `poll_count` increment.
- **Extra clocks.**
  - `nes_clk` edges in IDLE or LOAD are ignored.
  - Edges in DONE are ignored; `nes_data` stays 0 and nothing wraps.
- **Poll counter.** `poll_count` increments by 1 together with each `frame_done` pulse, modulo 256.
- **Simultaneous edges.** A latch rising edge and a clock rising edge in the same cycle: the latch wins, and the clock edge is dropped.
- **Reset.** Asserting `rst_n` low at any time, including mid-shift, forces:
  - state IDLE, `bit_idx` = 0, `sr` = all 1s, all synchroniser flops = 0;
  - outputs: `nes_data` = 1, `frame_done` = 0, `poll_count` = 0.

## Timing
- **Input-to-output latency.** `SYNC_STAGES`+1 `clk` cycles (3 at default) from a pin edge to the resulting `nes_data` change:
  - latch fall → first bit valid;
  - `nes_clk` rise → next bit.
- **Button capture.** Buttons are sampled `SYNC_STAGES` cycles behind the pins. The value delivered is the one captured on the last LOAD cycle before the latch fall is detected.
- **`frame_done`.** Asserted high for exactly one cycle, on the cycle the Nth clock edge is detected. `poll_count` updates on that same edge.
- **Minimum protocol widths.** Latch high, `nes_clk` high and `nes_clk` low must each be ≥ `SYNC_STAGES`+2 `clk` cycles. Shorter pulses may be lost; this is not an error condition.
- **Outputs.** All outputs are registered. There is no combinational path from any input to `nes_data`.

## Configuration
- **`NES_PAD_SNES_EN` defined:** 16-bit SNES frame.
  - Bits 0–11 carry `buttons` in SNES order.
  - Bits 12–15 carry 1 (released/ID bits).
  - DONE is entered after 16 clocks.
- **`NES_PAD_SNES_EN` undefined:** 8-bit NES frame.
  - Only `buttons[7:0]` are used; `buttons[11:8]` are unused.
  - DONE is entered after 8 clocks.
  - `sr[15:8]` may be removed in synthesis.

## Test plan
- **NES, buttons = 12'h011** (A, Up): latch pulse, then 8 clocks. `nes_data` bit sequence = 0,1,1,1,0,1,1,1; then 0 after the 8th clock. One `frame_done` pulse; `poll_count` 0 → 1.
- **SNES, buttons = 12'hA00** (X, R): 16 clocks. Bits 9 and 11 = 0, all other bits 0–15 = 1. `nes_data` = 0 after the 16th clock.
- **Mid-shift abort:** latch re-asserted after 3 clocks. `frame_done` stays 0, `poll_count` is unchanged, and the frame restarts from bit 0 with freshly captured buttons.
- **Stray and simultaneous edges:** 5 clocks during IDLE produce no output change. A clock edge coincident with the latch rise is dropped: after the latch fall, the first bit remains `sr[0]`.
- **Wrap and reset:** 256 complete polls leave `poll_count` = 0. Asserting `rst_n` low mid-shift forces `nes_data` = 1, `poll_count` = 0, state IDLE. On release, the next poll behaves normally.
